// File: rtl/subbytes_seq_if.sv
// Handshake bundle for the time-multiplexed SubBytes engine: input state port,
// result port and busy status.
interface subbytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/subbytes_seq.sv
// AES SubBytes over LANES byte units per cycle (BEATS = 16/LANES), forward or
// inverse per state, with valid/ready on both sides.
package subbytes_seq_pkg;
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 via exponents 1,3,7,...,127 then a final square; maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] y;
        y = a;
        for (int unsigned i = 0; i < 6; i++) y = gf_mul(gf_mul(y, y), a);
        return gf_mul(y, y);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = gf_inv(a);
        return t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction
endpackage

module subbytes_seq_sbox (
    input  logic       clk,
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    import subbytes_seq_pkg::*;

    always_ff @(posedge clk) begin
        o_byte <= fwd_sbox(i_byte);
    end
endmodule

module subbytes_seq #(
    parameter int LANES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    subbytes_seq_if.slave  s_bus
);
    import subbytes_seq_pkg::*;

    localparam int BEATS = 16 / LANES;
    localparam int BW    = $clog2(BEATS + 1);
    localparam int LW    = 8 * LANES;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [127:0]    r_data;
    logic            r_inv;
    logic [BW-1:0]   r_beat;
    logic [BW-1:0]   r_sb_beat;
    logic            r_sb_valid;
    logic [127:0]    r_res;
    logic [LW-1:0]   r_inv_q;
    logic [LW-1:0]   w_lane_in;
    logic [LW-1:0]   w_fwd;
    logic [LW-1:0]   w_sub;
    logic [127:0]    w_wb_raw;
    logic [127:0]    w_wb_rawmask;
    logic [127:0]    w_wb_data;
    logic [127:0]    w_wb_mask;
    logic            w_accept;
    logic            w_last;

    assign w_accept = (r_state == IDLE) && s_bus.in_valid;
    // r_beat == BEATS is the drain cycle that lets the last sbox result land
    assign w_last   = (r_beat == BW'(BEATS));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)        w_next = RUN;
            RUN:     if (w_last)          w_next = DONE;
            DONE:    if (s_bus.out_ready) w_next = IDLE;
            default:                      w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_inv      <= 1'b0;
            r_beat     <= '0;
            r_sb_beat  <= '0;
            r_sb_valid <= 1'b0;
            r_res      <= '0;
        end else begin
            r_sb_valid <= (r_state == RUN) && !w_last;
            r_sb_beat  <= r_beat;
            if (w_accept) begin
                r_data <= s_bus.in_data;
                r_inv  <= s_bus.in_inv;
                r_beat <= '0;
            end else if ((r_state == RUN) && !w_last) begin
                r_beat <= r_beat + 1'b1;
            end
            if (r_sb_valid) r_res <= (r_res & ~w_wb_mask) | w_wb_data;
        end
    end

    // Beat k's bytes are shifted to the top of the word; the drain beat shifts everything out
    always_comb begin
        w_lane_in = LW'((r_data << (32'(r_beat) * 32'(LW))) >> (128 - LW));
    end

    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            subbytes_seq_sbox u_fwd (
                .clk    (clk),
                .i_byte (w_lane_in[LW-1-8*j -: 8]),
                .o_byte (w_fwd[LW-1-8*j -: 8])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int unsigned j = 0; j < LANES; j++) begin
            r_inv_q[LW-1-8*j -: 8] <= inv_sbox(w_lane_in[LW-1-8*j -: 8]);
        end
    end

    assign w_sub = r_inv ? r_inv_q : w_fwd;

    always_comb begin
        w_wb_raw                 = '0;
        w_wb_rawmask             = '0;
        w_wb_raw[127 -: LW]      = w_sub;
        w_wb_rawmask[127 -: LW]  = '1;
        w_wb_data = w_wb_raw     >> (32'(r_sb_beat) * 32'(LW));
        w_wb_mask = w_wb_rawmask >> (32'(r_sb_beat) * 32'(LW));
    end

    assign s_bus.in_ready  = (r_state == IDLE);
    assign s_bus.out_valid = (r_state == DONE);
    assign s_bus.busy      = (r_state != IDLE);
    assign s_bus.out_data  = r_res;
endmodule
